// File: rtl/ysyx_23060236_lsu_sbuf.sv
// Load/store unit with an in-order posted-store buffer, store-to-load forwarding
// and independent load (AR/R) and drain (AW/W/B) engines on an AXI-lite port.
module ysyx_23060236_lsu_sbuf #(
  parameter int SB_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  // Every channel transfers on a cycle where valid & ready are both high;
  // a valid, once raised, holds its payload stable until that cycle.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_val,
  input  logic        fence,
  output logic        sb_empty,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        bus_err,
  output logic [31:0] lsu_araddr,
  output logic        lsu_arvalid,
  output logic [2:0]  lsu_arsize,
  input  logic        lsu_arready,
  input  logic [31:0] lsu_rdata,
  input  logic [1:0]  lsu_rresp,
  input  logic        lsu_rvalid,
  output logic        lsu_rready,
  output logic [31:0] lsu_awaddr,
  output logic        lsu_awvalid,
  output logic [2:0]  lsu_awsize,
  input  logic        lsu_awready,
  output logic [31:0] lsu_wdata,
  output logic [3:0]  lsu_wstrb,
  output logic        lsu_wvalid,
  input  logic        lsu_wready,
  input  logic [1:0]  lsu_bresp,
  input  logic        lsu_bvalid,
  output logic        lsu_bready,
  output logic [1:0]  load_state,
  output logic [1:0]  drain_state
);

  localparam int AW = $clog2(SB_DEPTH);

  typedef enum logic [1:0] {L_IDLE, L_AR, L_R, L_WAIT} load_t;
  typedef enum logic [1:0] {D_IDLE, D_ADDR, D_RESP} drain_t;

  load_t  l_state, l_next;
  drain_t d_state, d_next;

  logic [29:0]         sb_addr [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [3:0]          sb_strb [SB_DEPTH];
  logic [1:0]          sb_size [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [AW:0]         wptr, rptr;
  logic [AW-1:0]       head;
  logic                full, empty;

  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        aw_pend, w_pend;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b010:  load_ext = sh;
      3'b100:  load_ext = {24'h0, sh[7:0]};
      3'b101:  load_ext = {16'h0, sh[15:0]};
      default: load_ext = 32'h0;
    endcase
  endfunction

  assign head  = rptr[AW-1:0];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Request decode
  logic       accept, is_mem, misaligned, st_accept, ld_accept;
  logic [3:0] req_mask, needed;

  assign req_ready  = (l_state == L_IDLE) & ~fence & ~(req_wen & full);
  assign accept     = req_valid & req_ready;
  assign is_mem     = req_ren | req_wen;
  assign misaligned = is_mem & (((req_funct3[1:0] == 2'd1) & req_addr[0]) |
                                ((req_funct3[1:0] == 2'd2) & (req_addr[1:0] != 2'd0)));
  assign st_accept  = accept & req_wen & ~misaligned;
  assign ld_accept  = accept & req_ren & ~req_wen & ~misaligned;
  assign req_mask   = size_mask(req_funct3[1:0]);
  assign needed     = req_mask << req_addr[1:0];

  // Scanning oldest to youngest leaves the youngest matching entry in fwd_idx.
  logic          fwd_match, wait_match, fwd_hit;
  logic [AW-1:0] fwd_idx, scan_idx;
  logic [31:0]   fwd_data;

  always_comb begin
    fwd_match  = 1'b0;
    wait_match = 1'b0;
    fwd_idx    = '0;
    scan_idx   = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      scan_idx = head + AW'(k);
      if (sb_vld[scan_idx] && (sb_addr[scan_idx] == req_addr[31:2])) begin
        fwd_match = 1'b1;
        fwd_idx   = scan_idx;
      end
      if (sb_vld[k] && (sb_addr[k] == ld_addr[31:2])) wait_match = 1'b1;
    end
  end

  assign fwd_hit  = fwd_match && ((sb_strb[fwd_idx] & needed) == needed);
  assign fwd_data = load_ext(sb_data[fwd_idx], req_addr[1:0], req_funct3);

  // Load FSM
  always_comb begin
    l_next = l_state;
    case (l_state)
      L_IDLE: if (ld_accept && !fwd_hit) l_next = fwd_match ? L_WAIT : L_AR;
      L_AR:   if (lsu_arready) l_next = L_R;
      L_R:    if (lsu_rvalid) l_next = L_IDLE;
      L_WAIT: if (!wait_match) l_next = L_AR;
      default: l_next = L_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      l_state   <= L_IDLE;
      ld_addr   <= 32'h0;
      ld_funct3 <= 3'h0;
    end else begin
      l_state <= l_next;
      if (ld_accept) begin
        ld_addr   <= req_addr;
        ld_funct3 <= req_funct3;
      end
    end
  end

  // Drain FSM
  logic dequeue;

  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE: if (!empty) d_next = D_ADDR;
      D_ADDR: if ((!aw_pend || lsu_awready) && (!w_pend || lsu_wready)) d_next = D_RESP;
      D_RESP: if (lsu_bvalid) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  assign dequeue = (d_state == D_RESP) & lsu_bvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      d_state <= D_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      d_state <= d_next;
      if (d_state == D_IDLE && d_next == D_ADDR) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else begin
        if (lsu_awready) aw_pend <= 1'b0;
        if (lsu_wready)  w_pend  <= 1'b0;
      end
      if (dequeue && lsu_bresp != 2'b00) bus_err <= 1'b1;
    end
  end

  // Enqueue is refused when full, so it never collides with the head slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      sb_vld <= '0;
    end else begin
      if (st_accept) begin
        sb_vld[wptr[AW-1:0]] <= 1'b1;
        wptr                 <= wptr + 1'b1;
      end
      if (dequeue) begin
        sb_vld[head] <= 1'b0;
        rptr         <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (st_accept) begin
      sb_addr[wptr[AW-1:0]] <= req_addr[31:2];
      sb_data[wptr[AW-1:0]] <= req_wdata << {req_addr[1:0], 3'b000};
      sb_strb[wptr[AW-1:0]] <= needed;
      sb_size[wptr[AW-1:0]] <= req_funct3[1:0];
    end
  end

  // Writeback: immediate responses and bus-read completions never coincide
  // because requests are only accepted while the load FSM is idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (accept && (misaligned || !is_mem || req_wen || fwd_hit)) begin
        resp_valid <= 1'b1;
        resp_err   <= misaligned;
        if (misaligned || req_wen) resp_data <= 32'h0;
        else if (!is_mem)          resp_data <= req_val;
        else                       resp_data <= fwd_data;
      end else if (l_state == L_R && lsu_rvalid) begin
        resp_valid <= 1'b1;
        resp_data  <= load_ext(lsu_rdata, ld_addr[1:0], ld_funct3);
        resp_err   <= (lsu_rresp != 2'b00);
      end
    end
  end

  assign lsu_araddr  = ld_addr;
  assign lsu_arvalid = (l_state == L_AR);
  assign lsu_arsize  = {1'b0, ld_funct3[1:0]};
  assign lsu_rready  = 1'b1;
  assign lsu_awaddr  = {sb_addr[head], 2'b00};
  assign lsu_awvalid = aw_pend;
  assign lsu_awsize  = {1'b0, sb_size[head]};
  assign lsu_wdata   = sb_data[head];
  assign lsu_wstrb   = sb_strb[head];
  assign lsu_wvalid  = w_pend;
  assign lsu_bready  = 1'b1;
  assign sb_empty    = empty & (d_state == D_IDLE);
  assign load_state  = l_state;
  assign drain_state = d_state;

endmodule

// File: tb/tb_ysyx_23060236_lsu_sbuf.sv
// Bench for the store-buffered LSU: scoreboarded writeback, an AXI-lite slave
// with its own memory, and an architectural reference memory for expectations.
module tb_ysyx_23060236_lsu_sbuf;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_ren, req_wen;
  logic [31:0] req_addr, req_wdata, req_val;
  logic [2:0]  req_funct3;
  logic        fence, sb_empty, resp_valid, resp_err, bus_err;
  logic [31:0] resp_data;
  logic [31:0] lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [2:0]  lsu_arsize, lsu_awsize;
  logic [1:0]  lsu_rresp, lsu_bresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [3:0]  lsu_wstrb;
  logic [1:0]  load_state, drain_state;

  always #5 clock = ~clock;

  ysyx_23060236_lsu_sbuf #(.SB_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3), .req_val(req_val),
    .fence(fence), .sb_empty(sb_empty),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .bus_err(bus_err),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arsize(lsu_arsize),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awsize(lsu_awsize),
    .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .load_state(load_state), .drain_state(drain_state)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] slv_mem [int];
  int          ar_cnt = 0, aw_cnt = 0, b_cnt = 0, ar_rise_b = -1;
  bit          aw_en = 1'b1, rand_rdy = 1'b0, r_hold = 1'b0;
  logic [1:0]  next_bresp = 2'b00, next_rresp = 2'b00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(int'(a[31:2])) ? ref_mem[int'(a[31:2])] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_word(input logic [31:0] a);
    return slv_mem.exists(int'(a[31:2])) ? slv_mem[int'(a[31:2])] : 32'h0;
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [2:0] f3);
    return (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_word(a);
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return w;
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    ref_mem[int'(a[31:2])] = w;
    slv_mem[int'(a[31:2])] = w;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] val,
                       input logic [32:0] e);
    int n = 0;
    req_valid = 1'b1; req_ren = ren; req_wen = wen; req_addr = a;
    req_wdata = wd; req_funct3 = f3; req_val = val;
    #1;
    while (!req_ready && n < 500) begin @(posedge clock); #1; n++; end
    if (!req_ready) check("req_ready_timeout", req_ready, 1);
    else exp_q.push_back(e);
    @(posedge clock); #1;
    req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
  endtask

  task automatic op_nop(input logic [31:0] v);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, v, {1'b0, v});
  endtask

  task automatic op_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    logic [32:0] e;
    logic [31:0] w;
    if (misal(a, f3)) e = {1'b1, 32'h0};
    else begin
      e = 33'h0;
      w = ref_word(a);
      case (f3[1:0])
        2'd0:    w[8*a[1:0] +: 8] = d[7:0];
        2'd1:    w[16*a[1] +: 16] = d[15:0];
        default: w = d;
      endcase
      ref_mem[int'(a[31:2])] = w;
    end
    drive(1'b0, 1'b1, a, d, f3, 32'h0, e);
  endtask

  task automatic op_ld(input logic [31:0] a, input logic [2:0] f3, input bit err);
    logic [32:0] e;
    e = misal(a, f3) ? {1'b1, 32'h0} : {err, exp_load(a, f3)};
    drive(1'b1, 1'b0, a, 32'h0, f3, 32'h0, e);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clock); #1; n++; end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!sb_empty && n < 2000) begin @(posedge clock); #1; n++; end
    check(tag, sb_empty, 1);
  endtask

  // AXI-lite slave plus writeback scoreboard; samples mid-cycle, drives after the edge.
  initial begin : bus_slave
    bit          aw_got = 0, w_got = 0, ar_got = 0, ar_prev = 0, b_fire, r_fire;
    logic [31:0] aw_a = 0, w_d = 0, ar_a = 0, w;
    logic [3:0]  w_s = 0;
    logic [32:0] e;
    lsu_arready = 1'b1; lsu_rvalid = 1'b0; lsu_rdata = 32'h0; lsu_rresp = 2'b00;
    lsu_awready = 1'b1; lsu_wready = 1'b1; lsu_bvalid = 1'b0; lsu_bresp = 2'b00;
    forever begin
      @(negedge clock);
      if (reset) begin
        aw_got = 0; w_got = 0; ar_got = 0;
      end else begin
        if (lsu_awvalid && lsu_awready) begin aw_got = 1; aw_a = lsu_awaddr; aw_cnt++; end
        if (lsu_wvalid && lsu_wready) begin w_got = 1; w_d = lsu_wdata; w_s = lsu_wstrb; end
        if (lsu_arvalid && lsu_arready) begin ar_got = 1; ar_a = lsu_araddr; ar_cnt++; end
        if (lsu_arvalid && !ar_prev) ar_rise_b = b_cnt;
        if (lsu_bvalid) b_cnt++;
        if (resp_valid) begin
          if (exp_q.size() == 0) check("resp_unexpected", {resp_err, resp_data}, 33'h0);
          else begin
            e = exp_q.pop_front();
            check("resp", {resp_err, resp_data}, e);
          end
        end
      end
      ar_prev = lsu_arvalid;
      b_fire  = lsu_bvalid;
      r_fire  = lsu_rvalid;
      @(posedge clock); #1;
      if (reset) begin
        lsu_bvalid = 1'b0; lsu_rvalid = 1'b0;
      end else begin
        if (b_fire) lsu_bvalid = 1'b0;
        if (r_fire) lsu_rvalid = 1'b0;
        if (aw_got && w_got && !lsu_bvalid) begin
          w = slv_word(aw_a);
          for (int i = 0; i < 4; i++) if (w_s[i]) w[8*i +: 8] = w_d[8*i +: 8];
          slv_mem[int'(aw_a[31:2])] = w;
          lsu_bvalid = 1'b1; lsu_bresp = next_bresp; next_bresp = 2'b00;
          aw_got = 0; w_got = 0;
        end
        if (ar_got && !lsu_rvalid && !r_hold) begin
          lsu_rvalid = 1'b1; lsu_rdata = slv_word(ar_a);
          lsu_rresp = next_rresp; next_rresp = 2'b00; ar_got = 0;
        end
      end
      lsu_awready = rand_rdy ? 1'($urandom_range(0, 1)) : aw_en;
      lsu_wready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a0, w0, b0;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [2:0]  ld_f3 [5];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
    reset = 1'b1; fence = 1'b0; req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
    req_addr = 0; req_wdata = 0; req_funct3 = 0; req_val = 0;
    preload(32'h400, 32'hCAFEF00D);
    preload(32'h200, 32'h11223344);
    cycles(3);
    reset = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_req_ready", req_ready, 1);
    check("rst_arvalid", lsu_arvalid, 0);
    check("rst_awvalid", lsu_awvalid, 0);
    cycles(1);

    op_nop(32'h12345678);
    op_nop(32'h0BADF00D);
    wait_done("nop_done");

    // Store then load with AW held off: forwarded, no read issued
    aw_en = 1'b0; cycles(2);
    a0 = ar_cnt;
    op_st(32'h100, 32'hDEADBEEF, 3'd2);
    op_ld(32'h100, 3'd2, 1'b0);
    check("fwd_latency", resp_valid, 1);
    op_st(32'h101, 32'h00000080, 3'd0);
    op_ld(32'h101, 3'd0, 1'b0);
    op_ld(32'h101, 3'd4, 1'b0);
    wait_done("fwd_done");
    check("fwd_no_ar", ar_cnt, a0);

    // Fill the buffer, then a store is refused but an unrelated load proceeds
    op_st(32'h300, 32'hA5A5A5A5, 3'd2);
    op_st(32'h306, 32'h0000BEEF, 3'd1);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h308; req_funct3 = 3'd2; #1;
    check("full_refuses_store", req_ready, 0);
    req_valid = 1'b0; req_wen = 1'b0;
    op_ld(32'h400, 3'd2, 1'b0);
    op_ld(32'h402, 3'd5, 1'b0);
    op_ld(32'h400, 3'd6, 1'b0);
    wait_done("full_load_done");
    check("full_load_ar", ar_cnt, a0 + 3);

    b0 = b_cnt;
    aw_en = 1'b1; fence = 1'b1; #1;
    check("fence_blocks", req_ready, 0);
    wait_empty("fence_drain4");
    fence = 1'b0;
    check("drain4_b_count", b_cnt, b0 + 4);
    check("mem_100", slv_word(32'h100), ref_word(32'h100));
    check("mem_300", slv_word(32'h300), ref_word(32'h300));
    check("mem_304", slv_word(32'h304), ref_word(32'h304));

    // Partial overlap: load waits for the B of the covering store
    aw_en = 1'b0; cycles(2);
    op_st(32'h200, 32'h0000005A, 3'd0);
    b0 = b_cnt;
    op_ld(32'h200, 3'd2, 1'b0);
    cycles(5);
    check("overlap_in_wait", load_state, 2'd3);
    check("overlap_no_arvalid", lsu_arvalid, 0);
    aw_en = 1'b1;
    wait_done("overlap_done");
    check("ar_after_b", ar_rise_b > b0, 1);

    // Fence with three buffered stores, one returning SLVERR
    aw_en = 1'b0; cycles(2);
    check("bus_err_clear", bus_err, 0);
    op_st(32'h500, 32'h11111111, 3'd2);
    op_st(32'h504, 32'h22222222, 3'd2);
    op_st(32'h508, 32'h33333333, 3'd2);
    wait_done("three_st_resp");
    b0 = b_cnt;
    next_bresp = 2'b10;
    fence = 1'b1; #1;
    check("fence_not_empty", sb_empty, 0);
    aw_en = 1'b1;
    wait_empty("fence_drain3");
    fence = 1'b0;
    check("drain3_b_count", b_cnt, b0 + 3);
    check("bus_err_set", bus_err, 1);
    op_st(32'h50C, 32'h44444444, 3'd2);
    wait_empty("drain_after_err");
    check("bus_err_sticky", bus_err, 1);
    next_rresp = 2'b10;
    op_ld(32'h400, 3'd2, 1'b1);
    wait_done("rresp_done");

    // Misaligned accesses touch neither channel
    a0 = ar_cnt; w0 = aw_cnt;
    op_ld(32'h103, 3'd1, 1'b0);
    op_st(32'h102, 32'hFFFFFFFF, 3'd2);
    op_ld(32'h401, 3'd2, 1'b0);
    wait_done("misal_done");
    cycles(2);
    check("misal_no_ar", ar_cnt, a0);
    check("misal_no_aw", aw_cnt, w0);
    check("misal_sb_empty", sb_empty, 1);

    // Random mix against the reference memory with random write-channel readiness
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = 32'h600 + 32'(4 * $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: begin
          f3 = 3'($urandom_range(0, 2));
          if (f3 == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
          else if (f3 == 3'd1) a[1] = 1'($urandom_range(0, 1));
          op_st(a, $urandom, f3);
        end
        1: begin
          f3 = ld_f3[$urandom_range(0, 4)];
          if (f3[1:0] == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
          else if (f3[1:0] == 2'd1) a[1] = 1'($urandom_range(0, 1));
          op_ld(a, f3, 1'b0);
        end
        default: op_nop($urandom);
      endcase
    end
    wait_done("rand_done");
    rand_rdy = 1'b0;
    fence = 1'b1;
    wait_empty("rand_drain");
    fence = 1'b0;
    for (int i = 0; i < 4; i++)
      check("rand_mem", slv_word(32'h600 + 32'(4 * i)), ref_word(32'h600 + 32'(4 * i)));

    // Reset while a read sits in L_R with a store still buffered
    aw_en = 1'b0; r_hold = 1'b1; cycles(2);
    op_st(32'h700, 32'h77777777, 3'd2);
    op_ld(32'h400, 3'd2, 1'b0);
    begin
      int n = 0;
      while (load_state != 2'd2 && n < 100) begin @(posedge clock); #1; n++; end
    end
    check("reached_l_r", load_state, 2'd2);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    exp_q.delete();
    ref_mem.delete(int'(32'h700 >> 2));
    #1;
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_err", resp_err, 0);
    check("mid_rst_resp_data", resp_data, 0);
    check("mid_rst_bus_err", bus_err, 0);
    check("mid_rst_sb_empty", sb_empty, 1);
    check("mid_rst_arvalid", lsu_arvalid, 0);
    check("mid_rst_awvalid", lsu_awvalid, 0);
    check("mid_rst_wvalid", lsu_wvalid, 0);
    check("mid_rst_load_state", load_state, 0);
    check("mid_rst_req_ready", req_ready, 1);
    r_hold = 1'b0; aw_en = 1'b1;
    cycles(2);
    op_ld(32'h400, 3'd0, 1'b0);
    wait_done("post_rst_load");

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_lsu_sbuf.md
# ysyx_23060236_lsu_sbuf

Load/store unit with a parametrised, in-order posted-store buffer and store-to-load forwarding. It sits between EXU and the AXI-lite memory bus, in the same slot as the current LSU. Stores retire to writeback as soon as they are buffered and drain to the bus in the background. Loads either forward from the buffer or issue a bus read, and the unit stalls only on partial overlap.

## Interface
- `SB_DEPTH`, default 4: store-buffer entries; power of 2, ≥2.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1 / `req_ready` out 1: EXU request handshake.
- `req_ren`, `req_wen` in 1: load or store. Neither set means a non-memory op; both set is illegal.
- `req_addr` in 32: effective address; `req_wdata` in 32: store data, low-aligned.
- `req_funct3` in 3: RV32 width/sign encoding.
- `req_val` in 32: result passed through for non-memory ops.
- `fence` in 1: level request to drain the buffer; `sb_empty` out 1.
- `resp_valid` out 1, `resp_data` out 32, `resp_err` out 1: writeback pulse.
- `bus_err` out 1: sticky flag, set by a non-OKAY `bresp`.
- Read channel: `lsu_araddr` out 32, `lsu_arvalid` out 1, `lsu_arsize` out 3, `lsu_arready` in 1, `lsu_rdata` in 32, `lsu_rresp` in 2, `lsu_rvalid` in 1, `lsu_rready` out 1.
- Write channel: `lsu_awaddr` out 32, `lsu_awvalid` out 1, `lsu_awsize` out 3, `lsu_awready` in 1, `lsu_wdata` out 32, `lsu_wstrb` out 4, `lsu_wvalid` out 1, `lsu_wready` in 1, `lsu_bresp` in 2, `lsu_bvalid` in 1, `lsu_bready` out 1.

## Operation
- **Buffer:** circular FIFO with fields {word addr [31:2], shifted data, byte strobe, size}.
  - Pointers are log2(SB_DEPTH)+1 bits wide, so full/empty is decided by the extra MSB.
  - Stored form: `wstrb = mask << addr[1:0]`, `wdata = data << 8*addr[1:0]`. `mask` is 1/3/F for funct3[1:0] = 0/1/2.
- **Misalignment:** halfword with addr[0]=1, or word with addr[1:0]≠0. The request is accepted, makes no bus access and no buffer write, and returns `resp_valid` with `resp_err`=1 and `resp_data`=0.
- **`req_ready`** = (load FSM in L_IDLE) & ~fence & ~(req_wen & full).
  - An enqueue is refused when full, even if a dequeue happens the same cycle.
- **Non-memory op:** `resp_data` = `req_val`.
- **Store:** enqueue at the tail; `resp_data` = 0.
- **Load lookup**, done in the acceptance cycle against all valid entries with a matching word address:
  - No match: go to L_AR.
  - Youngest match covers every needed byte (needed = mask << addr[1:0]): forward. `resp_data` = extracted bytes, no bus access.
  - Otherwise: go to L_WAIT.
- **Load FSM:**
  - L_IDLE → L_AR (arvalid=1) → L_R on arready → L_IDLE on rvalid.
  - L_WAIT → L_AR once no valid entry matches the word address. Forwarding is not retried.
- **Load data extract:** `shift = rdata >> 8*addr[1:0]`, then by funct3:
  - lb: sign-extend bits [7:0].
  - lh: sign-extend bits [15:0].
  - lw: pass through.
  - lbu: zero-extend bits [7:0].
  - lhu: zero-extend bits [15:0].
  - Any other funct3: 0.
  - `resp_err` = (rresp≠0).
- **Drain FSM**, operating on the head entry:
  - D_IDLE → D_ADDR when the buffer is non-empty. On entry, assert `awvalid` and `wvalid` together; each drops independently on its own ready.
  - D_ADDR → D_RESP when both handshakes are done, including the same-cycle case.
  - D_RESP → D_IDLE on bvalid: dequeue the head, and OR (bresp≠0) into `bus_err`.
- **Fixed bus outputs:**
  - `lsu_rready` = `lsu_bready` = 1.
  - `arsize`/`awsize` = {0, funct3[1:0]}.
- **Fence:**
  - Blocks new requests while high.
  - `sb_empty` = (count==0) & drain FSM in D_IDLE.

## Timing
- **Reset values:**
  - All valids, `resp_valid`, `resp_err`, `bus_err` = 0.
  - Pointers = 0; `sb_empty` = 1.
  - Both FSMs in IDLE; `resp_data` = 0.
- **Reset mid-transaction:** in-flight reads and buffered stores are discarded.
- **Latencies:**
  - Non-memory op, store, forward hit, misaligned: `resp_valid` in the cycle after acceptance.
  - Load miss: `arvalid` the cycle after acceptance; `resp_valid` the cycle after the R handshake.
  - A store accepted at cycle t is visible to lookup at t+1. Its drain may start at t+1 if the buffer was empty.
- **Response shape:** `resp_valid` is a one-cycle pulse. `resp_data` holds until the next pulse.
- **Concurrency:** a load wait or read and a store drain may overlap on the bus. `lsu_araddr` stays stable while `arvalid` is high.
- **Dequeue vs. lookup:** a dequeue in the same cycle as a lookup is not seen by that lookup. Lookup uses the pre-dequeue state.

## Test plan
- **Store then load, same address:** sw 0xDEADBEEF @0x100, then lw @0x100 with awready held low → `resp_data`=0xDEADBEEF one cycle after the load is accepted; no `arvalid`.
- **Byte forward:** sb 0x80 @0x101, then lb @0x101 → 0xFFFFFF80; lbu → 0x00000080.
- **Partial overlap:** sb @0x200, then lw @0x200 → load waits in L_WAIT. `arvalid` rises only after the B handshake for 0x200; the result comes from `rdata`.
- **Full buffer:** SB_DEPTH stores with awready=0 → `req_ready`=0 for the next store; a load to an unrelated address is still accepted.
- **Fence and errors:**
  - 3 buffered stores, then `fence`=1 → `sb_empty` rises after the third B.
  - A `bresp`=2 on one store sets `bus_err` sticky.
  - An `rresp`=2 on a load gives `resp_err`=1.
- **Misaligned:** lh @0x103 → `resp_err`=1, `resp_data`=0, no AR/AW. A reset asserted during L_R returns all outputs to their reset values.
